eth_wb_reg_bridge: RTL and testbench
====================================

ETH_WB_REG_BRIDGE -- requirements
Module: eth_wb_reg_bridge

Interface
REQ-001 SHALL have parameter WB_DW, default 32, Wishbone data width; legal 16/32/64.
REQ-002 SHALL have parameter REG_DW, default 16, register-port data width; N = WB_DW/REG_DW SHALL be 1, 2 or 4.
REQ-003 SHALL have parameter REG_AW, default 8, register word-address width.
REQ-004 SHALL have parameter TIMEOUT, default 255, wait-cycle limit per beat, range 1..65535.
REQ-005 Clk_reg  in  1  the single clock; all logic on rising edge.
REQ-006 Reset  in  1  asynchronous, active-high reset.
REQ-007 wb_adr_i  in  16  byte address.
REQ-008 wb_dat_i  in  WB_DW  write data.
REQ-009 wb_sel_i  in  WB_DW/8  byte enables.
REQ-010 wb_stb_i / wb_we_i  in  1 each  strobe, write.
REQ-011 wb_dat_o  out  WB_DW  read data; wb_ack_o, wb_err_o  out  1 each.
REQ-012 reg_cs_o, reg_we_o  out  1 each  register select, write.
REQ-013 reg_adr_o  out  REG_AW  register word address; reg_dat_o  out  REG_DW  write data.
REQ-014 reg_dat_i  in  REG_DW  read data; reg_rdy_i  in  1  beat completes when high with reg_cs_o high.

Function
REQ-015 States SHALL be IDLE, BEAT, ACK; IDLE->BEAT on wb_stb_i high with wb_ack_o/wb_err_o low, latching adr, dat, sel, we and setting beat=0.
REQ-016 Each Wishbone access SHALL be split into N register beats, beat 0 = least-significant REG_DW lane.
REQ-017 reg_adr_o SHALL be wb_adr_i[REG_AW+log2(REG_DW/8)-1 : log2(REG_DW/8)] with its low log2(N) bits replaced by beat index.
REQ-018 In BEAT, reg_cs_o SHALL be high and held with address/data stable until reg_rdy_i is high.
REQ-019 Write beats whose REG_DW/8 sel bits are all zero SHALL be skipped (no reg_cs_o cycle); read beats SHALL never be skipped.
REQ-020 Read beats SHALL capture reg_dat_i into the matching wb_dat_o lane on the cycle reg_rdy_i is high; other lanes hold.
REQ-021 After the last beat the FSM SHALL enter ACK, drive wb_ack_o high exactly one cycle, then return to IDLE.
REQ-022 With reg_rdy_i tied high and no skips, wb_ack_o SHALL assert N+1 cycles after the accepting edge.
REQ-023 If wb_stb_i drops mid-access, the current beat SHALL complete, remaining beats SHALL be dropped, no ack SHALL issue, FSM SHALL return to IDLE.
REQ-024 A write with wb_sel_i all zero SHALL go straight to ACK (one-cycle latency).
REQ-025 wb_ack_o and wb_err_o SHALL never be high together.

Reset
REQ-026 On Reset: state IDLE, beat 0; wb_ack_o, wb_err_o, reg_cs_o, reg_we_o 0; wb_dat_o, reg_adr_o, reg_dat_o all zero.
REQ-027 Reset mid-access SHALL abort immediately with no ack or err after release.

Configuration
REQ-028 With ETH_WB_BRIDGE_TIMEOUT_EN defined, a per-beat counter SHALL count cycles with reg_cs_o high and reg_rdy_i low; reaching TIMEOUT SHALL abort remaining beats and pulse wb_err_o one cycle instead of wb_ack_o.
REQ-029 Without ETH_WB_BRIDGE_TIMEOUT_EN, beats SHALL wait indefinitely and wb_err_o SHALL be constant 0.

Structure
REQ-030 Shared package eth_wb_bridge_pkg SHALL hold state encodings and a clog2 function.
REQ-031 Timeout counter SHALL be sub-module eth_wb_bridge_timer, instantiated only under the macro.

Verification
REQ-032 WB_DW=32/REG_DW=16, write adr 0x0010 dat 0xAABBCCDD sel 0xF, rdy high -> beats at reg_adr 0x08 (0xCCDD) then 0x09 (0xAABB), ack 3 cycles after accept.
REQ-033 Read adr 0x0010, reg_dat_i 0x1234 then 0x5678 -> wb_dat_o 0x56781234 with ack.
REQ-034 Write sel 0xC -> single beat at reg_adr 0x09 only, ack 2 cycles after accept.
REQ-035 Macro on, TIMEOUT=4, rdy low -> wb_err_o one pulse after 4 wait cycles, no ack, FSM IDLE.
REQ-036 wb_stb_i dropped during beat 0 with rdy low 2 cycles -> beat 0 completes, no beat 1, no ack.
REQ-037 Reset asserted during beat 1 -> all outputs zero asynchronously, no ack after release.

Source files
------------

// File: rtl/eth_wb_bridge_pkg.sv
// Shared definitions for the Ethernet Wishbone-to-register bridge:
// FSM state encoding and a constant-foldable ceil(log2) helper.
package eth_wb_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BEAT = 2'd1,
        ST_ACK  = 2'd2
    } bridge_state_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_wb_bridge_timer.sv
// Per-beat wait counter for the bridge; exists only when ETH_WB_BRIDGE_TIMEOUT_EN
// is defined. Counts while i_run is high and clears whenever it drops.
`ifdef ETH_WB_BRIDGE_TIMEOUT_EN
module eth_wb_bridge_timer #(
    parameter int LIMIT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_run,
    output logic o_expired
);

    logic [15:0] r_cnt;

    // Expiry fires on the LIMIT-th consecutive wait cycle.
    assign o_expired = i_run && (r_cnt == 16'(LIMIT - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (!i_run) begin
            r_cnt <= '0;
        end else if (!o_expired) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

endmodule
`endif

// File: rtl/eth_wb_reg_bridge.sv
// Wishbone slave that splits each access into WB_DW/REG_DW register-port beats.
// Optional per-beat timeout with error response under ETH_WB_BRIDGE_TIMEOUT_EN.
module eth_wb_reg_bridge
    import eth_wb_bridge_pkg::*;
#(
    parameter int WB_DW   = 32,
    parameter int REG_DW  = 16,
    parameter int REG_AW  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                  Clk_reg,
    input  logic                  Reset,
    input  logic [15:0]           wb_adr_i,
    input  logic [WB_DW-1:0]      wb_dat_i,
    input  logic [WB_DW/8-1:0]    wb_sel_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    output logic [WB_DW-1:0]      wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  reg_cs_o,
    output logic                  reg_we_o,
    output logic [REG_AW-1:0]     reg_adr_o,
    output logic [REG_DW-1:0]     reg_dat_o,
    input  logic [REG_DW-1:0]     reg_dat_i,
    input  logic                  reg_rdy_i
);

    localparam int N      = WB_DW / REG_DW;
    localparam int LANE_B = REG_DW / 8;
    localparam int SEL_W  = WB_DW / 8;
    localparam int LSB    = clog2(LANE_B);
    localparam int NB     = clog2(N);
    localparam int BEAT_W = (NB == 0) ? 1 : NB;

    if ((WB_DW != 16 && WB_DW != 32 && WB_DW != 64) || (REG_DW % 8 != 0) ||
        (N != 1 && N != 2 && N != 4) || (N * REG_DW != WB_DW) ||
        (TIMEOUT < 1) || (TIMEOUT > 65535) ||
        (REG_AW + LSB > 16) || (REG_AW <= NB)) begin : g_bad_param
        $error("eth_wb_reg_bridge: illegal parameter combination");
    end

    bridge_state_t       r_state;
    bridge_state_t       w_state_nxt;
    logic [REG_AW-1:0]   r_adr;
    logic [WB_DW-1:0]    r_dat;
    logic [WB_DW-1:0]    r_rdat;
    logic [SEL_W-1:0]    r_sel;
    logic                r_we;
    logic [BEAT_W-1:0]   r_beat;
    logic [BEAT_W-1:0]   w_beat_nxt;
    logic                r_abort;
    logic                r_err_flag;
    logic                r_ack;
    logic                w_accept;
    logic                w_set_err;
    logic                w_stop;
    logic                w_timeout;
    logic                w_first_ok;
    logic [BEAT_W-1:0]   w_first;
    logic                w_next_ok;
    logic [BEAT_W-1:0]   w_next;
    logic                w_unused;

    // A write lane with no byte enables is skipped; read lanes always run.
    function automatic logic lane_active(input logic [SEL_W-1:0] sel,
                                         input logic             we,
                                         input int               lane);
        return !we || (sel[lane*LANE_B +: LANE_B] != '0);
    endfunction

    always_comb begin
        w_first_ok = 1'b0;
        w_first    = '0;
        w_next_ok  = 1'b0;
        w_next     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (lane_active(wb_sel_i, wb_we_i, i)) begin
                w_first_ok = 1'b1;
                w_first    = BEAT_W'(i);
            end
            if ((i > int'(r_beat)) && lane_active(r_sel, r_we, i)) begin
                w_next_ok = 1'b1;
                w_next    = BEAT_W'(i);
            end
        end
    end

    assign w_stop = r_abort || !wb_stb_i;

    always_ff @(posedge Clk_reg or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_accept    = 1'b0;
        w_set_err   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (wb_stb_i && !wb_ack_o && !wb_err_o) begin
                    w_accept    = 1'b1;
                    w_beat_nxt  = w_first;
                    w_state_nxt = w_first_ok ? ST_BEAT : ST_ACK;
                end
            end
            ST_BEAT: begin
                if (reg_rdy_i) begin
                    if (w_stop) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_next_ok) begin
                        w_beat_nxt = w_next;
                    end else begin
                        w_state_nxt = ST_ACK;
                    end
                end else if (w_timeout) begin
                    // A master that already withdrew gets no error response either.
                    if (w_stop) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_ACK;
                        w_set_err   = 1'b1;
                    end
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk_reg or posedge Reset) begin
        if (Reset) begin
            r_beat     <= '0;
            r_abort    <= 1'b0;
            r_err_flag <= 1'b0;
            r_ack      <= 1'b0;
            r_we       <= 1'b0;
            r_sel      <= '0;
            r_adr      <= '0;
            r_dat      <= '0;
            r_rdat     <= '0;
        end else begin
            r_beat <= w_beat_nxt;
            r_ack  <= (r_state == ST_ACK) && !r_err_flag;
            if (w_accept) begin
                r_adr      <= wb_adr_i[LSB +: REG_AW];
                r_dat      <= wb_dat_i;
                r_sel      <= wb_sel_i;
                r_we       <= wb_we_i;
                r_abort    <= 1'b0;
                r_err_flag <= 1'b0;
            end else if ((r_state == ST_BEAT) && !wb_stb_i) begin
                r_abort <= 1'b1;
            end
            if (w_set_err) begin
                r_err_flag <= 1'b1;
            end
            if ((r_state == ST_BEAT) && reg_rdy_i && !r_we) begin
                r_rdat[int'(r_beat)*REG_DW +: REG_DW] <= reg_dat_i;
            end
        end
    end

    assign wb_dat_o  = r_rdat;
    assign wb_ack_o  = r_ack;
    assign reg_cs_o  = (r_state == ST_BEAT);
    assign reg_we_o  = reg_cs_o && r_we;
    assign reg_dat_o = r_dat[int'(r_beat)*REG_DW +: REG_DW];

    // The beat index replaces the lane-select bits of the word address.
    if (NB == 0) begin : g_adr_single
        assign reg_adr_o = r_adr;
    end else begin : g_adr_multi
        assign reg_adr_o = {r_adr[REG_AW-1:NB], r_beat};
    end

    assign w_unused = ^{wb_adr_i, r_adr};

`ifdef ETH_WB_BRIDGE_TIMEOUT_EN
    logic w_tmr_run;
    logic r_err;

    assign w_tmr_run = reg_cs_o && !reg_rdy_i;

    eth_wb_bridge_timer #(
        .LIMIT (TIMEOUT)
    ) u_timer (
        .i_clk     (Clk_reg),
        .i_rst     (Reset),
        .i_run     (w_tmr_run),
        .o_expired (w_timeout)
    );

    always_ff @(posedge Clk_reg or posedge Reset) begin
        if (Reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (r_state == ST_ACK) && r_err_flag;
        end
    end

    assign wb_err_o = r_err;
`else
    assign w_timeout = 1'b0;
    assign wb_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_eth_wb_reg_bridge.sv
// Bench for eth_wb_reg_bridge (WB_DW=32, REG_DW=16): vector table plus
// hand sequences for stb drop, reset mid-access and (if enabled) timeout.
`timescale 1ns/1ps
module tb_eth_wb_reg_bridge;

    typedef struct {
        logic        we;
        logic [15:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          wait_n;
        int          exp_lat;
        logic [31:0] exp_rd;
    } vec_t;

    typedef struct {
        logic [7:0]  adr;
        logic        we;
        logic [15:0] dat;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        stb;
    logic        we;
    logic [31:0] dat_o;
    logic        ack;
    logic        err;
    logic        cs;
    logic        rwe;
    logic [7:0]  radr;
    logic [15:0] rdat_o;
    logic [15:0] rdat_i;
    logic        rdy;

    int          n_vec = 0;
    int          n_fail = 0;
    int          wait_n = 0;
    int          wcnt = 0;
    logic        mem_load;
    logic [15:0] mem [0:255];
    beat_t       exp_q[$];
    vec_t        tbl [13];

    eth_wb_reg_bridge #(
        .WB_DW   (32),
        .REG_DW  (16),
        .REG_AW  (8),
        .TIMEOUT (4)
    ) dut (
        .Clk_reg   (clk),
        .Reset     (rst),
        .wb_adr_i  (adr),
        .wb_dat_i  (dat),
        .wb_sel_i  (sel),
        .wb_stb_i  (stb),
        .wb_we_i   (we),
        .wb_dat_o  (dat_o),
        .wb_ack_o  (ack),
        .wb_err_o  (err),
        .reg_cs_o  (cs),
        .reg_we_o  (rwe),
        .reg_adr_o (radr),
        .reg_dat_o (rdat_o),
        .reg_dat_i (rdat_i),
        .reg_rdy_i (rdy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_word(input int i);
        if (i == 8) return 16'h1234;
        if (i == 9) return 16'h5678;
        return {8'h5A, 8'(i)};
    endfunction

    // Register-side slave: memory plus a programmable wait count per beat.
    assign rdat_i = mem[radr];
    assign rdy    = (wcnt >= wait_n);

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (cs && rdy && rwe) begin
            mem[radr] <= rdat_o;
        end
        if (cs && !rdy) wcnt <= wcnt + 1;
        else            wcnt <= 0;
    end

    // Scoreboard: every completed beat must match the next expected one.
    always @(negedge clk) begin
        beat_t e;
        if (cs && rdy) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL beat_unexpected: adr=%h we=%b dat=%h, required no beat", radr, rwe, rdat_o);
            end else begin
                e = exp_q.pop_front();
                if (radr !== e.adr || rwe !== e.we || (e.we && rdat_o !== e.dat)) begin
                    n_fail++;
                    $display("FAIL beat: adr=%h we=%b dat=%h, required adr=%h we=%b dat=%h",
                             radr, rwe, rdat_o, e.adr, e.we, e.dat);
                end
            end
        end
        if (ack && err) begin
            n_vec++;
            n_fail++;
            $display("FAIL ack_err_overlap: ack=%b err=%b, required not both", ack, err);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // Called 1 time unit after a rising edge; returns at the same phase.
    task automatic run_access(input logic we_v, input logic [15:0] adr_v, input logic [31:0] dat_v,
                              input logic [3:0] sel_v, input int wait_v, input int exp_lat,
                              input logic [31:0] exp_rd, input logic exp_err, input string nm);
        int          lat;
        bit          seen;
        logic [7:0]  wd;
        beat_t       bt;
        wait_n = wait_v;
        wd = adr_v[8:1];
        if (!exp_err) begin
            for (int b = 0; b < 2; b++) begin
                if (!we_v || sel_v[2*b +: 2] != 2'b00) begin
                    bt.adr = {wd[7:1], b[0]};
                    bt.we  = we_v;
                    bt.dat = dat_v[16*b +: 16];
                    exp_q.push_back(bt);
                end
            end
        end
        we = we_v; adr = adr_v; dat = dat_v; sel = sel_v; stb = 1'b1;
        @(posedge clk);
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
            if (ack || err) seen = 1'b1;
        end
        stb = 1'b0;
        n_vec++;
        if (!seen || lat != exp_lat || ack !== !exp_err || err !== exp_err) begin
            n_fail++;
            $display("FAIL %s_resp: seen=%0d lat=%0d ack=%b err=%b, required lat=%0d ack=%b err=%b",
                     nm, seen, lat, ack, err, exp_lat, !exp_err, exp_err);
        end
        if (!seen) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            exp_q.delete();
        end else begin
            if (!we_v && !exp_err) chk({nm, "_rdata"}, 64'(dat_o), 64'(exp_rd));
            @(posedge clk);
            #1;
            chk({nm, "_pulse_len"}, 64'({ack, err}), 64'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw;
        mem_load = 1'b1;
        rst = 1'b1;
        stb = 1'b0; we = 1'b0; adr = '0; dat = '0; sel = '0;
        wait_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_cs", 64'(cs), 64'd0);
        chk("rst_we", 64'(rwe), 64'd0);
        chk("rst_wbdat", 64'(dat_o), 64'd0);
        chk("rst_radr", 64'(radr), 64'd0);
        chk("rst_rdat", 64'(rdat_o), 64'd0);
        mem_load = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        tbl[0]  = '{1'b0, 16'h0010, 32'h0000_0000, 4'hF, 0, 3, 32'h5678_1234};
        tbl[1]  = '{1'b1, 16'h0010, 32'hAABB_CCDD, 4'hF, 0, 3, 32'h0};
        tbl[2]  = '{1'b0, 16'h0010, 32'h0000_0000, 4'hF, 1, 5, 32'hAABB_CCDD};
        tbl[3]  = '{1'b1, 16'h0010, 32'h1122_3344, 4'hC, 0, 2, 32'h0};
        tbl[4]  = '{1'b0, 16'h0012, 32'h0000_0000, 4'hF, 0, 3, 32'h1122_CCDD};
        tbl[5]  = '{1'b1, 16'h0020, 32'hDEAD_BEEF, 4'h0, 0, 1, 32'h0};
        tbl[6]  = '{1'b0, 16'h0020, 32'h0000_0000, 4'hF, 0, 3, 32'h5A11_5A10};
        tbl[7]  = '{1'b1, 16'h01FC, 32'h0F0E_0D0C, 4'h3, 2, 4, 32'h0};
        tbl[8]  = '{1'b0, 16'h01FC, 32'h0000_0000, 4'hF, 3, 9, 32'h5AFF_0D0C};
        tbl[9]  = '{1'b1, 16'hFE04, 32'h9988_7766, 4'hF, 0, 3, 32'h0};
        tbl[10] = '{1'b0, 16'h0004, 32'h0000_0000, 4'hF, 0, 3, 32'h9988_7766};
        tbl[11] = '{1'b1, 16'h0030, 32'h0000_4455, 4'h1, 0, 2, 32'h0};
        tbl[12] = '{1'b0, 16'h0030, 32'h0000_0000, 4'hF, 0, 3, 32'h5A19_4455};

        for (int k = 0; k < 13; k++) begin
            run_access(tbl[k].we, tbl[k].adr, tbl[k].dat, tbl[k].sel, tbl[k].wait_n,
                       tbl[k].exp_lat, tbl[k].exp_rd, 1'b0, $sformatf("vec%0d", k));
        end
        chk("table_beats_left", 64'(exp_q.size()), 64'd0);

        // stb withdrawn while beat 0 is still waiting
        wait_n = 2;
        exp_q.push_back('{8'h20, 1'b0, 16'h0000});
        we = 1'b0; adr = 16'h0040; sel = 4'hF; stb = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        stb = 1'b0;
        saw = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (ack || err) saw = 1'b1;
        end
        chk("drop_no_resp", 64'(saw), 64'd0);
        chk("drop_cs_idle", 64'(cs), 64'd0);
        chk("drop_beats_left", 64'(exp_q.size()), 64'd0);

        // reset asserted while beat 1 of a write is waiting
        wait_n = 3;
        exp_q.push_back('{8'h28, 1'b1, 16'h2222});
        we = 1'b1; adr = 16'h0050; dat = 32'h1111_2222; sel = 4'hF; stb = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        chk("rstmid_in_beat1", 64'({cs, radr}), 64'h129);
        rst = 1'b1;
        #1;
        chk("rstmid_cs", 64'(cs), 64'd0);
        chk("rstmid_we", 64'(rwe), 64'd0);
        chk("rstmid_radr", 64'(radr), 64'd0);
        chk("rstmid_rdat", 64'(rdat_o), 64'd0);
        chk("rstmid_wbdat", 64'(dat_o), 64'd0);
        chk("rstmid_resp", 64'({ack, err}), 64'd0);
        stb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        saw = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (ack || err) saw = 1'b1;
        end
        chk("rstmid_no_resp", 64'(saw), 64'd0);
        chk("rstmid_beats_left", 64'(exp_q.size()), 64'd0);

        run_access(1'b0, 16'h0010, 32'h0, 4'hF, 0, 3, 32'h1122_CCDD, 1'b0, "post_rst");

`ifdef ETH_WB_BRIDGE_TIMEOUT_EN
        run_access(1'b0, 16'h0060, 32'h0, 4'hF, 1000, 5, 32'h0, 1'b1, "timeout");
        chk("timeout_idle", 64'(cs), 64'd0);
        wait_n = 0;
`endif

        chk("final_beats_left", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
